// File: rtl/noise_pkg.sv
// Shared types and constants for the LFSR noise generator: FSM states, default seed, tap mask,
// and the single-step LFSR function.
package noise_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_OUT  = 2'd2
    } noise_state_t;

    localparam logic [15:0] NOISE_DEF_SEED = 16'hACE1;
    // Taps at bits 15,13,12,10 (maximal-length 16-bit polynomial).
    localparam logic [15:0] NOISE_TAP_MASK = 16'hB400;

    // One Fibonacci step; an all-zero state would lock up, so it reloads the seed instead.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l, input logic [15:0] seed);
        if (l == 16'h0000) begin
            return seed;
        end
        return {l[14:0], ^(l & NOISE_TAP_MASK)};
    endfunction

endpackage

// File: rtl/rate_edge_sync.sv
// Two-flop synchroniser for the divided rate clock plus a registered rising-edge detector.
// tick_o is a one-cycle pulse three clk edges after the rate_i rise.
module rate_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rate_i,
    output logic tick_o
);

    // sync_q[0..1] form the synchroniser; sync_q[2] remembers the previous synchronised level.
    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], rate_i};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/lfsr_noise_gen.sv
// White-noise sample source: one LFSR step per rising edge of rate_clk, scaled sample offered
// over valid/ready. Optional runtime seed loading when NOISE_SEED_LOAD_EN is defined.
module lfsr_noise_gen
    import noise_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter int                DATA_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rate_clk,
    input  logic              enable,
    input  logic [1:0]        amp_sel,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              ovr_flag,
    input  logic              ovr_clr
`ifdef NOISE_SEED_LOAD_EN
    ,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in
`endif
);

    localparam logic [LFSR_W-1:0] RST_SEED = (SEED == '0) ? NOISE_DEF_SEED : SEED;

    noise_state_t      state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [DATA_W-1:0] sample_q, sample_d, scaled;
    logic              ovr_q, ovr_d, ovr_set;
    logic              tick, tick_en;
    logic signed [DATA_W-1:0] top_s;

    rate_edge_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rate_i (rate_clk),
        .tick_o (tick)
    );

    assign tick_en   = tick & enable;
    assign lfsr_step = lfsr_next(lfsr_q, RST_SEED);
    assign top_s     = lfsr_step[LFSR_W-1 -: DATA_W];
    assign scaled    = top_s >>> amp_sel;

    // Handshake: sample_valid stays high with sample_out stable until a cycle where
    // sample_valid && sample_ready; that cycle transfers the sample. A tick that arrives while
    // the sample is still unconsumed advances the LFSR, keeps the old sample and sets ovr_flag.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        sample_d = sample_q;
        ovr_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_en) state_d = S_STEP;
            end
            S_STEP: begin
                lfsr_d   = lfsr_step;
                sample_d = scaled;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (tick_en && sample_ready) begin
                    state_d = S_STEP;
                end else if (tick_en) begin
                    ovr_set = 1'b1;
                    lfsr_d  = lfsr_step;
                end else if (sample_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
`ifdef NOISE_SEED_LOAD_EN
        if (seed_load) begin
            lfsr_d   = (seed_in == '0) ? NOISE_DEF_SEED : seed_in;
            state_d  = S_IDLE;
            sample_d = sample_q;
            ovr_d    = ovr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lfsr_q   <= RST_SEED;
            sample_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = (state_q == S_OUT);
    assign ovr_flag     = ovr_q;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Self-checking bench for lfsr_noise_gen: reset, fixed vector table, hand sequences for
// latency/overrun/reset/tied-high, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_lfsr_noise_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rate_clk = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  amp_sel = 2'd0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        ovr_flag;
    logic        ovr_clr = 1'b0;
`ifdef NOISE_SEED_LOAD_EN
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    bit          sb_on = 1'b0;

    logic [15:0] m_lfsr;
    bit          m_pend;
    bit          m_ovr;

    always #5 clk = ~clk;

    lfsr_noise_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rate_clk     (rate_clk),
        .enable       (enable),
        .amp_sel      (amp_sel),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ovr_flag     (ovr_flag),
        .ovr_clr      (ovr_clr)
`ifdef NOISE_SEED_LOAD_EN
        ,
        .seed_load    (seed_load),
        .seed_in      (seed_in)
`endif
    );

    typedef struct {
        bit          en;
        logic [1:0]  amp;
        bit          exp_valid;
        logic [15:0] exp_sample;
        logic [15:0] exp_lfsr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1 as arithmetic: double, wrap, add parity of tap bits.
    function automatic logic [15:0] model_next(input logic [15:0] l);
        int p;
        int n;
        if (l == 16'h0000) return 16'hACE1;
        p = $countones(l & 16'hB400) % 2;
        n = (int'(l) * 2 + p) % 65536;
        return n[15:0];
    endfunction

    // Two's-complement value divided by 2^a, rounded towards minus infinity.
    function automatic logic [15:0] model_scale(input logic [15:0] l, input int a);
        int v;
        int d;
        v = int'(l);
        if (v >= 32768) v = v - 65536;
        d = 1 << a;
        if (v < 0) v = -((-v + d - 1) / d);
        else       v = v / d;
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        if (sb_on) begin
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got sample 0x%0h expected no transfer", sample_out);
                end else begin
                    check("sb_sample", sample_out, exp_q.pop_front());
                end
            end
            check("lfsr_nonzero", (dut.lfsr_q != 16'h0000) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   r, e;
        int   a;

        vecs[0] = '{1'b1, 2'd0, 1'b1, 16'h59C3, 16'h59C3};
        vecs[1] = '{1'b1, 2'd1, 1'b1, 16'hD9C3, 16'hB387};
        vecs[2] = '{1'b0, 2'd2, 1'b0, 16'hD9C3, 16'hB387};
        vecs[3] = '{1'b1, 2'd3, 1'b1, 16'h0CE1, 16'h670F};
        vecs[4] = '{1'b1, 2'd2, 1'b1, 16'hF387, 16'hCE1E};

        @(posedge clk);
        #1;
        do_reset();
        check("rst_valid", sample_valid, 0);
        check("rst_ovr", ovr_flag, 0);
        check("rst_sample", sample_out, 16'h0000);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);
        cycles(2);

        // Vector table: one rate rise per row, exact 5-cycle latency, then consume.
        for (int i = 0; i < 5; i++) begin
            enable   = vecs[i].en;
            amp_sel  = vecs[i].amp;
            rate_clk = 1'b1;
            cycles(4);
            check("vec_early_valid", sample_valid, 0);
            cycles(1);
            check("vec_valid", sample_valid, vecs[i].exp_valid);
            check("vec_sample", sample_out, vecs[i].exp_sample);
            check("vec_lfsr", dut.lfsr_q, vecs[i].exp_lfsr);
            rate_clk     = 1'b0;
            sample_ready = 1'b1;
            cycles(1);
            sample_ready = 1'b0;
            check("vec_drained", sample_valid, 0);
            cycles(3);
        end

        // Attenuated sample held stable while the consumer stalls.
        do_reset();
        enable   = 1'b1;
        amp_sel  = 2'd2;
        rate_clk = 1'b1;
        cycles(5);
        check("amp2_sample", sample_out, 16'h1670);
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("stall_valid", sample_valid, 1);
            check("stall_sample", sample_out, 16'h1670);
        end
        rate_clk = 1'b0;

        // Overrun, clear, and clear colliding with a new overrun.
        do_reset();
        amp_sel  = 2'd0;
        rate_clk = 1'b1;
        cycles(5);
        check("ovr_first_sample", sample_out, 16'h59C3);
        rate_clk = 1'b0;
        cycles(3);
        rate_clk = 1'b1;
        cycles(5);
        check("ovr_set", ovr_flag, 1);
        check("ovr_sample_kept", sample_out, 16'h59C3);
        check("ovr_valid_kept", sample_valid, 1);
        check("ovr_lfsr_advanced", dut.lfsr_q, 16'hB387);
        rate_clk = 1'b0;
        cycles(3);
        ovr_clr = 1'b1;
        cycles(1);
        ovr_clr = 1'b0;
        check("ovr_cleared", ovr_flag, 0);
        rate_clk = 1'b1;
        cycles(3);
        ovr_clr = 1'b1;
        cycles(1);
        ovr_clr = 1'b0;
        check("ovr_set_wins", ovr_flag, 1);
        cycles(1);
        check("ovr_sticky", ovr_flag, 1);
        rate_clk = 1'b0;
        cycles(3);

        // Reset while a sample is pending.
        rst_n = 1'b0;
        cycles(1);
        check("midrst_valid", sample_valid, 0);
        check("midrst_sample", sample_out, 16'h0000);
        check("midrst_lfsr", dut.lfsr_q, 16'hACE1);
        check("midrst_ovr", ovr_flag, 0);
        rst_n = 1'b1;

        // rate_clk tied high through and after reset: exactly one tick.
        rst_n    = 1'b0;
        rate_clk = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);
        check("tied_valid", sample_valid, 1);
        check("tied_sample", sample_out, 16'h59C3);
        sample_ready = 1'b1;
        cycles(1);
        sample_ready = 1'b0;
        cycles(20);
        check("tied_no_retick", sample_valid, 0);
        check("tied_lfsr", dut.lfsr_q, 16'h59C3);
        rate_clk = 1'b0;
        cycles(4);

        // Randomized traffic against the transaction model.
        do_reset();
        cycles(2);
        m_lfsr = 16'hACE1;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        exp_q.delete();
        sb_on = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            r = ($urandom_range(0, 1) == 1);
            e = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 3);
            enable       = e;
            amp_sel      = a[1:0];
            sample_ready = r;
            if (r) m_pend = 1'b0;
            if (e) begin
                m_lfsr = model_next(m_lfsr);
                if (m_pend) begin
                    m_ovr = 1'b1;
                end else begin
                    exp_q.push_back(model_scale(m_lfsr, a));
                    m_pend = !r;
                end
            end
            rate_clk = 1'b1;
            cycles(4);
            rate_clk = 1'b0;
            cycles(4);
            check("rnd_valid", sample_valid, m_pend);
            check("rnd_ovr", ovr_flag, m_ovr);
            check("rnd_lfsr", dut.lfsr_q, m_lfsr);
            if ($urandom_range(0, 3) == 0) begin
                ovr_clr = 1'b1;
                cycles(1);
                ovr_clr = 1'b0;
                m_ovr   = 1'b0;
            end
        end
        enable       = 1'b0;
        sample_ready = 1'b1;
        ovr_clr      = 1'b1;
        cycles(2);
        ovr_clr = 1'b0;
        m_pend  = 1'b0;
        m_ovr   = 1'b0;
        check("rnd_drained", sample_valid, 0);
        check("rnd_queue_empty", exp_q.size(), 0);

        // Continuous consumer at the fastest comfortable rate: no overrun, model tracks the sequence.
        enable  = 1'b1;
        amp_sel = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            m_lfsr = model_next(m_lfsr);
            exp_q.push_back(model_scale(m_lfsr, 0));
            rate_clk = 1'b1;
            cycles(2);
            rate_clk = 1'b0;
            cycles(2);
        end
        cycles(6);
        check("run_lfsr", dut.lfsr_q, m_lfsr);
        check("run_ovr", ovr_flag, 0);
        check("run_queue_empty", exp_q.size(), 0);
        sb_on        = 1'b0;
        sample_ready = 1'b0;

`ifdef NOISE_SEED_LOAD_EN
        do_reset();
        enable   = 1'b1;
        amp_sel  = 2'd0;
        rate_clk = 1'b1;
        cycles(5);
        sample_ready = 1'b1;
        cycles(1);
        sample_ready = 1'b0;
        rate_clk     = 1'b0;
        cycles(3);
        check("seed_pre_lfsr", dut.lfsr_q, 16'h59C3);
        rate_clk = 1'b1;
        cycles(3);
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        cycles(1);
        seed_load = 1'b0;
        check("seed_lfsr", dut.lfsr_q, 16'hACE1);
        check("seed_valid", sample_valid, 0);
        cycles(3);
        check("seed_tick_dropped", sample_valid, 0);
        rate_clk = 1'b0;
        cycles(4);
        rate_clk = 1'b1;
        cycles(5);
        check("seed_next_sample", sample_out, 16'h59C3);
        check("seed_next_valid", sample_valid, 1);
        sample_ready = 1'b1;
        cycles(1);
        sample_ready = 1'b0;
        rate_clk     = 1'b0;
        cycles(3);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rate_clk = 1'b1;
            cycles(4);
            rate_clk = 1'b0;
            cycles(4);
        end
        check("dis_valid", sample_valid, 0);
        check("dis_lfsr", dut.lfsr_q, 16'h59C3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
